// File: rtl/spi_bus_arbiter.sv
// Arbitrates the flash SPI bus between the 6809 flash controller and the FT2232 writer.
// Every ownership change passes through a guard window that holds flash CS high.
module spi_bus_arbiter #(
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_cpu_req,
    input  logic       i_FT_CS,
    input  logic       i_cpu_spi_clk,
    input  logic       i_cpu_spi_mosi,
    input  logic       i_cpu_spi_cs,
    input  logic       i_wr_spi_clk,
    input  logic       i_wr_spi_mosi,
    input  logic       i_wr_spi_cs,
    output logic       o_SPI_CLK,
    output logic       o_SPI_MOSI,
    output logic       o_SPI_CS,
    output logic       o_cpu_grant,
    output logic       o_ft_grant,
    output logic       o_cpu_ready,
    output logic       o_cpu_abort,
    output logic [7:0] o_abort_count
);

    localparam int unsigned CntW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CntW-1:0] GuardLoad = CntW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCpu, StFt, StGuard} state_e;

    state_e          state_q, state_d;
    logic [1:0]      cpu_sync_q, ft_sync_q;
    logic            cpu_req_s, ft_req_s;
    logic            target_ft_q, target_ft_d;
    logic [CntW-1:0] guard_cnt_q, guard_cnt_d;
    logic            abort_d, ready_d;
    logic            cpu_grant_q, ft_grant_q, ready_q, abort_q;
    logic [7:0]      abort_count_q;

    assign cpu_req_s = cpu_sync_q[1];
    assign ft_req_s  = ft_sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_sync_q <= '0;
            ft_sync_q  <= '0;
        end else begin
            cpu_sync_q <= {cpu_sync_q[0], i_cpu_req};
            ft_sync_q  <= {ft_sync_q[0], ~i_FT_CS};
        end
    end

    always_comb begin
        state_d     = state_q;
        target_ft_d = target_ft_q;
        guard_cnt_d = guard_cnt_q;
        abort_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ft_req_s) begin
                    state_d     = StGuard;
                    target_ft_d = 1'b1;
                    guard_cnt_d = GuardLoad;
                end else if (cpu_req_s) begin
                    state_d = StCpu;
                end
            end
            StCpu: begin
                // FT preempts; a transfer in flight (CS low) must be restarted by the CPU side
                if (ft_req_s) begin
                    state_d     = StGuard;
                    target_ft_d = 1'b1;
                    guard_cnt_d = GuardLoad;
                    abort_d     = ~i_cpu_spi_cs;
                end else if (!cpu_req_s && i_cpu_spi_cs) begin
                    state_d = StIdle;
                end
            end
            StFt: begin
                if (!ft_req_s) begin
                    state_d     = StGuard;
                    target_ft_d = 1'b0;
                    guard_cnt_d = GuardLoad;
                end
            end
            StGuard: begin
                if (guard_cnt_q == '0) begin
                    state_d     = (target_ft_q && ft_req_s) ? StFt : StIdle;
                    target_ft_d = 1'b0;
                end else begin
                    guard_cnt_d = guard_cnt_q - 1'b1;
                    // A withdrawn FT request retargets without restarting the count
                    if (!ft_req_s) target_ft_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Ready is computed from next-cycle values so it lines up with the registered grant
    assign ready_d = ~(cpu_sync_q[0] && (state_d != StCpu));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            target_ft_q   <= 1'b0;
            guard_cnt_q   <= '0;
            cpu_grant_q   <= 1'b0;
            ft_grant_q    <= 1'b0;
            ready_q       <= 1'b1;
            abort_q       <= 1'b0;
            abort_count_q <= '0;
        end else begin
            state_q     <= state_d;
            target_ft_q <= target_ft_d;
            guard_cnt_q <= guard_cnt_d;
            cpu_grant_q <= (state_d == StCpu);
            ft_grant_q  <= (state_d == StFt);
            ready_q     <= ready_d;
            abort_q     <= abort_d;
            if (abort_d && (abort_count_q != 8'hFF)) begin
                abort_count_q <= abort_count_q + 8'd1;
            end
        end
    end

    // Grants reset asynchronously, so the pins fall to idle levels the moment reset asserts
    always_comb begin
        o_SPI_CS   = 1'b1;
        o_SPI_CLK  = 1'b0;
        o_SPI_MOSI = 1'b0;
        if (cpu_grant_q) begin
            o_SPI_CS   = i_cpu_spi_cs;
            o_SPI_CLK  = i_cpu_spi_clk;
            o_SPI_MOSI = i_cpu_spi_mosi;
        end else if (ft_grant_q) begin
            o_SPI_CS   = i_wr_spi_cs;
            o_SPI_CLK  = i_wr_spi_clk;
            o_SPI_MOSI = i_wr_spi_mosi;
        end
    end

    assign o_cpu_grant   = cpu_grant_q;
    assign o_ft_grant    = ft_grant_q;
    assign o_cpu_ready   = ready_q;
    assign o_cpu_abort   = abort_q;
    assign o_abort_count = abort_count_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scenario bench for spi_bus_arbiter: expectations are queued as stimulus is applied
// and popped when the DUT reaches the observed event.
module tb_spi_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_cpu_req = 1'b0;
    logic       i_FT_CS = 1'b1;
    logic       i_cpu_spi_clk = 1'b0, i_cpu_spi_mosi = 1'b0, i_cpu_spi_cs = 1'b1;
    logic       i_wr_spi_clk = 1'b0, i_wr_spi_mosi = 1'b0, i_wr_spi_cs = 1'b1;
    logic       o_SPI_CLK, o_SPI_MOSI, o_SPI_CS;
    logic       o_cpu_grant, o_ft_grant, o_cpu_ready, o_cpu_abort;
    logic [7:0] o_abort_count;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    int          model_count = 0;

    spi_bus_arbiter #(.GUARD_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_cpu_req     (i_cpu_req),
        .i_FT_CS       (i_FT_CS),
        .i_cpu_spi_clk (i_cpu_spi_clk),
        .i_cpu_spi_mosi(i_cpu_spi_mosi),
        .i_cpu_spi_cs  (i_cpu_spi_cs),
        .i_wr_spi_clk  (i_wr_spi_clk),
        .i_wr_spi_mosi (i_wr_spi_mosi),
        .i_wr_spi_cs   (i_wr_spi_cs),
        .o_SPI_CLK     (o_SPI_CLK),
        .o_SPI_MOSI    (o_SPI_MOSI),
        .o_SPI_CS      (o_SPI_CS),
        .o_cpu_grant   (o_cpu_grant),
        .o_ft_grant    (o_ft_grant),
        .o_cpu_ready   (o_cpu_ready),
        .o_cpu_abort   (o_cpu_abort),
        .o_abort_count (o_abort_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        reset = 1'b0;
        repeat (3) tick();
        exp_q.push_back({24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        exp_q.push_back(32'd0);
        got = {24'd0, o_SPI_CS, o_SPI_CLK, o_SPI_MOSI, o_cpu_grant, o_ft_grant,
               o_cpu_ready, o_cpu_abort, 1'b0};
        e = exp_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected %b", got[7:0], e[7:0]);
        end
        e = exp_q.pop_front();
        total++;
        if ({24'd0, o_abort_count} !== e) begin
            bad++;
            $display("FAIL reset_count: got %0d expected %0d", o_abort_count, e);
        end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_cpu_grant();
        int          n;
        logic        ready2;
        logic [31:0] e;
        logic [2:0]  pat;
        i_cpu_spi_cs = 1'b1;
        i_cpu_req = 1'b1;
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        n = 0;
        ready2 = 1'b1;
        while (!o_cpu_grant && n < 20) begin
            tick();
            n++;
            if (n == 2) ready2 = o_cpu_ready;
        end
        e = exp_q.pop_front();
        total++;
        if (n !== int'(e)) begin
            bad++;
            $display("FAIL cpu_grant_latency: got %0d expected %0d", n, e);
        end
        e = exp_q.pop_front();
        total++;
        if ({31'd0, ready2} !== e) begin
            bad++;
            $display("FAIL cpu_ready_wait: got %0b expected %0b", ready2, e[0]);
        end
        e = exp_q.pop_front();
        total++;
        if ({31'd0, o_cpu_ready} !== e) begin
            bad++;
            $display("FAIL cpu_ready_granted: got %0b expected %0b", o_cpu_ready, e[0]);
        end
        for (int k = 0; k < 4; k++) begin
            pat = 3'(k * 3 + 1);
            {i_cpu_spi_cs, i_cpu_spi_clk, i_cpu_spi_mosi} = pat;
            {i_wr_spi_cs, i_wr_spi_clk, i_wr_spi_mosi} = ~pat;
            #1;
            exp_q.push_back({29'd0, pat});
            e = exp_q.pop_front();
            total++;
            if ({29'd0, o_SPI_CS, o_SPI_CLK, o_SPI_MOSI} !== e) begin
                bad++;
                $display("FAIL cpu_pins: got %b expected %b",
                         {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI}, e[2:0]);
            end
        end
        i_cpu_spi_cs = 1'b0;
        i_cpu_spi_clk = 1'b0;
        i_cpu_spi_mosi = 1'b0;
        i_wr_spi_cs = 1'b0;
        tick();
    endtask

    task automatic test_preempt();
        int          n, aborts, cs_high;
        logic [31:0] e;
        // CPU owns with CS low; FT asks for the bus
        i_FT_CS = 1'b0;
        model_count++;
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'(model_count));
        n = 0;
        aborts = 0;
        cs_high = 0;
        while (!o_ft_grant && n < 30) begin
            tick();
            n++;
            if (o_cpu_abort) aborts++;
            if (o_SPI_CS && !o_ft_grant) cs_high++;
        end
        tick();
        if (o_cpu_abort) aborts++;
        e = exp_q.pop_front();
        total++;
        if (n !== int'(e)) begin
            bad++;
            $display("FAIL preempt_ft_latency: got %0d expected %0d", n, e);
        end
        e = exp_q.pop_front();
        total++;
        if (aborts !== int'(e)) begin
            bad++;
            $display("FAIL preempt_abort_pulses: got %0d expected %0d", aborts, e);
        end
        e = exp_q.pop_front();
        total++;
        if (cs_high !== int'(e)) begin
            bad++;
            $display("FAIL preempt_guard_cs_high: got %0d expected %0d", cs_high, e);
        end
        e = exp_q.pop_front();
        total++;
        if ({24'd0, o_abort_count} !== e) begin
            bad++;
            $display("FAIL preempt_abort_count: got %0d expected %0d", o_abort_count, e);
        end
        {i_wr_spi_cs, i_wr_spi_clk, i_wr_spi_mosi} = 3'b011;
        {i_cpu_spi_cs, i_cpu_spi_clk, i_cpu_spi_mosi} = 3'b100;
        #1;
        exp_q.push_back(32'b011);
        e = exp_q.pop_front();
        total++;
        if ({29'd0, o_SPI_CS, o_SPI_CLK, o_SPI_MOSI} !== e) begin
            bad++;
            $display("FAIL ft_pins: got %b expected %b",
                     {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI}, e[2:0]);
        end
    endtask

    task automatic test_ft_release();
        int          n, no_grant;
        logic [31:0] e;
        i_cpu_spi_cs = 1'b1;
        i_cpu_req = 1'b1;
        repeat (3) tick();
        exp_q.push_back(32'd0);
        e = exp_q.pop_front();
        total++;
        if ({31'd0, o_cpu_ready} !== e) begin
            bad++;
            $display("FAIL ready_during_ft: got %0b expected %0b", o_cpu_ready, e[0]);
        end
        i_FT_CS = 1'b1;
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd1);
        n = 0;
        no_grant = 0;
        while (!o_cpu_grant && n < 30) begin
            tick();
            n++;
            if (!o_cpu_grant && !o_ft_grant && o_SPI_CS) no_grant++;
        end
        e = exp_q.pop_front();
        total++;
        if (n !== int'(e)) begin
            bad++;
            $display("FAIL release_cpu_latency: got %0d expected %0d", n, e);
        end
        e = exp_q.pop_front();
        total++;
        if (no_grant !== int'(e)) begin
            bad++;
            $display("FAIL release_idle_cycles: got %0d expected %0d", no_grant, e);
        end
        e = exp_q.pop_front();
        total++;
        if ({31'd0, o_cpu_ready} !== e) begin
            bad++;
            $display("FAIL release_ready: got %0b expected %0b", o_cpu_ready, e[0]);
        end
        i_cpu_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_simultaneous();
        int          n, ready_hi;
        logic        cpu_seen;
        logic [31:0] e;
        i_cpu_req = 1'b1;
        i_FT_CS = 1'b0;
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        n = 0;
        ready_hi = 0;
        cpu_seen = 1'b0;
        while (!o_ft_grant && n < 30) begin
            tick();
            n++;
            if (o_cpu_grant) cpu_seen = 1'b1;
            if (n >= 2 && o_cpu_ready) ready_hi++;
        end
        repeat (3) begin
            tick();
            if (o_cpu_grant) cpu_seen = 1'b1;
            if (o_cpu_ready) ready_hi++;
        end
        e = exp_q.pop_front();
        total++;
        if (n !== int'(e)) begin
            bad++;
            $display("FAIL simul_ft_latency: got %0d expected %0d", n, e);
        end
        e = exp_q.pop_front();
        total++;
        if ({31'd0, cpu_seen} !== e) begin
            bad++;
            $display("FAIL simul_cpu_grant: got %0b expected %0b", cpu_seen, e[0]);
        end
        e = exp_q.pop_front();
        total++;
        if (ready_hi !== int'(e)) begin
            bad++;
            $display("FAIL simul_ready_high_cycles: got %0d expected %0d", ready_hi, e);
        end
        i_cpu_req = 1'b0;
        i_FT_CS = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_guard_retarget();
        int          n;
        logic        ft_seen;
        logic [31:0] e;
        // Short FT pulse with a CPU request pending: the guard must drain on its
        // original count, then the CPU gets the bus
        i_cpu_req = 1'b1;
        i_FT_CS = 1'b0;
        tick();
        tick();
        i_FT_CS = 1'b1;
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd0);
        n = 2;
        ft_seen = 1'b0;
        while (!o_cpu_grant && n < 30) begin
            tick();
            n++;
            if (o_ft_grant) ft_seen = 1'b1;
        end
        e = exp_q.pop_front();
        total++;
        if (n !== int'(e)) begin
            bad++;
            $display("FAIL retarget_cpu_latency: got %0d expected %0d", n, e);
        end
        e = exp_q.pop_front();
        total++;
        if ({31'd0, ft_seen} !== e) begin
            bad++;
            $display("FAIL retarget_ft_grant: got %0b expected %0b", ft_seen, e[0]);
        end
        i_cpu_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_saturate();
        int          n;
        logic [31:0] e;
        i_cpu_spi_cs = 1'b0;
        i_cpu_req = 1'b1;
        n = 0;
        while (!o_cpu_grant && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 300; i++) begin
            i_FT_CS = 1'b0;
            n = 0;
            while (!o_ft_grant && n < 20) begin
                tick();
                n++;
            end
            if (!o_ft_grant) begin
                total++;
                bad++;
                $display("FAIL saturate_ft_timeout: iteration %0d got no grant", i);
                break;
            end
            model_count = (model_count == 255) ? 255 : model_count + 1;
            exp_q.push_back(32'(model_count));
            e = exp_q.pop_front();
            total++;
            if ({24'd0, o_abort_count} !== e) begin
                bad++;
                $display("FAIL saturate_count: got %0d expected %0d", o_abort_count, e);
            end
            i_FT_CS = 1'b1;
            n = 0;
            while (!o_cpu_grant && n < 30) begin
                tick();
                n++;
            end
        end
        exp_q.push_back(32'hFF);
        e = exp_q.pop_front();
        total++;
        if ({24'd0, o_abort_count} !== e) begin
            bad++;
            $display("FAIL saturate_final: got %0d expected %0d", o_abort_count, e);
        end
        i_cpu_spi_cs = 1'b1;
        i_cpu_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        int          n;
        logic [31:0] e;
        i_FT_CS = 1'b0;
        n = 0;
        while (!o_ft_grant && n < 20) begin
            tick();
            n++;
        end
        i_wr_spi_cs = 1'b0;
        i_wr_spi_clk = 1'b1;
        #1;
        exp_q.push_back(32'b01);
        e = exp_q.pop_front();
        total++;
        if ({30'd0, o_SPI_CS, o_SPI_CLK} !== e) begin
            bad++;
            $display("FAIL mid_ft_pins: got %b expected %b", {o_SPI_CS, o_SPI_CLK}, e[1:0]);
        end
        // Assert reset between clock edges; pins must idle without waiting for a clock
        reset = 1'b0;
        #1;
        exp_q.push_back(32'b10);
        exp_q.push_back(32'd0);
        e = exp_q.pop_front();
        total++;
        if ({30'd0, o_SPI_CS, o_SPI_CLK} !== e) begin
            bad++;
            $display("FAIL async_reset_pins: got %b expected %b",
                     {o_SPI_CS, o_SPI_CLK}, e[1:0]);
        end
        e = exp_q.pop_front();
        total++;
        if ({22'd0, o_ft_grant, o_cpu_grant, o_abort_count} !== e) begin
            bad++;
            $display("FAIL async_reset_state: got %h expected %h",
                     {o_ft_grant, o_cpu_grant, o_abort_count}, e);
        end
        i_FT_CS = 1'b1;
        i_wr_spi_cs = 1'b1;
        i_wr_spi_clk = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (5) tick();
        exp_q.push_back({24'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0});
        e = exp_q.pop_front();
        total++;
        if ({24'd0, o_ft_grant, o_cpu_grant, o_cpu_ready, o_SPI_CS, 4'd0} !== e ||
            o_abort_count !== 8'd0) begin
            bad++;
            $display("FAIL after_reset_idle: got %b count %0d expected %b count 0",
                     {o_ft_grant, o_cpu_grant, o_cpu_ready, o_SPI_CS}, o_abort_count, e[7:4]);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_grant();
        test_preempt();
        test_ft_release();
        test_simultaneous();
        test_guard_retarget();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
